// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: frame formats, receiver states and FIFO entries.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    // Unused data bits are held at zero, so reducing over all 8 bits is safe.
    function automatic logic parity_err(input logic [7:0] data, input logic sample,
                                        input parity_t mode);
        return (^data ^ sample) != (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; shared by the RX and TX paths.
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees a slot, so a full FIFO can still accept the push.
    assign do_push = push & (~full | do_pop);
    assign count   = count_reg;
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM, per-byte error flags
// and a FWFT receive FIFO drained through valid/ready.
module uart_rx_fifo import uart_pkg::*; #(
    parameter int BIT_PERIOD = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in,
    output logic [7:0]                      out,
    output logic                            out_perr,
    output logic                            out_ferr,
    output logic                            valid,
    input  logic                            ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overrun,
    input  logic                            clr_overrun
);
    localparam int            HALF     = BIT_PERIOD / 2;
    localparam int            TW       = $clog2(BIT_PERIOD) + 1;
    localparam logic [TW-1:0] T_HALF   = TW'(HALF - 1);
    localparam logic [TW-1:0] T_BIT    = TW'(BIT_PERIOD - 1);
    localparam logic [2:0]    B_LAST   = 3'(DATA_BITS - 1);
    localparam logic          S_LAST   = 1'(STOP_BITS - 1);
    localparam parity_t       PAR_MODE = parity_t'(PARITY);

    logic          sync1_reg, rx_s_reg;
    rx_state_t     state_reg;
    logic [TW-1:0] timer_reg;
    logic [2:0]    bit_reg;
    logic          stop_reg;
    logic [7:0]    data_reg;
    logic          perr_reg, ferr_reg;
    logic          overrun_reg;

    logic          tick, push, full, empty, drop;
    rx_entry_t     push_entry, head;

    assign tick = (state_reg == START) ? (timer_reg == T_HALF) : (timer_reg == T_BIT);
    // The entry is pushed in the cycle of the last stop sample, so that sample is folded in here.
    assign push = (state_reg == STOP) && tick && (stop_reg == S_LAST);
    assign push_entry = '{perr: perr_reg, ferr: ferr_reg | ~rx_s_reg, data: data_reg};
    assign drop = push & full & ~(ready & ~empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
            state_reg <= IDLE;
            timer_reg <= '0;
            bit_reg   <= '0;
            stop_reg  <= 1'b0;
            data_reg  <= '0;
            perr_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            sync1_reg <= in;
            rx_s_reg  <= sync1_reg;
            if (state_reg != IDLE && state_reg != BREAK)
                timer_reg <= tick ? '0 : timer_reg + 1'b1;
            case (state_reg)
                IDLE: begin
                    timer_reg <= '0;
                    if (!rx_s_reg)
                        state_reg <= START;
                end
                START: if (tick) begin
                    if (rx_s_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        state_reg <= DATA;
                        bit_reg   <= '0;
                        data_reg  <= '0;
                        perr_reg  <= 1'b0;
                        ferr_reg  <= 1'b0;
                    end
                end
                DATA: if (tick) begin
                    data_reg[bit_reg] <= rx_s_reg;
                    if (bit_reg == B_LAST) begin
                        state_reg <= (PARITY != 0) ? uart_pkg::PARITY : STOP;
                        stop_reg  <= 1'b0;
                    end else begin
                        bit_reg <= bit_reg + 1'b1;
                    end
                end
                uart_pkg::PARITY: if (tick) begin
                    perr_reg  <= parity_err(data_reg, rx_s_reg, PAR_MODE);
                    state_reg <= STOP;
                    stop_reg  <= 1'b0;
                end
                STOP: if (tick) begin
                    if (!rx_s_reg)
                        ferr_reg <= 1'b1;
                    if (stop_reg == S_LAST)
                        state_reg <= (ferr_reg | ~rx_s_reg) ? BREAK : IDLE;
                    else
                        stop_reg <= 1'b1;
                end
                BREAK: if (rx_s_reg)
                    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overrun_reg <= 1'b0;
        else if (drop)
            overrun_reg <= 1'b1;
        else if (clr_overrun)
            overrun_reg <= 1'b0;
    end

    uart_fifo #(
        .WIDTH($bits(rx_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_entry),
        .pop     (ready),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign out      = head.data;
    assign out_perr = head.perr;
    assign out_ferr = head.ferr;
    assign valid    = ~empty;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receiver configurations (8N1/16, 7O1/16, 8N1/4) share clock and reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic line_a = 1'b1, line_b = 1'b1, line_c = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0, clr_c = 1'b0;

    logic [7:0] out_a, out_b, out_c;
    logic       perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c;
    logic       valid_a, valid_b, valid_c, ovr_a, ovr_b, ovr_c;
    logic [4:0] count_a, count_b;
    logic [2:0] count_c;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_a[$], exp_b[$], exp_c[$];

    uart_rx_fifo #(.BIT_PERIOD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .in(line_a), .out(out_a), .out_perr(perr_a), .out_ferr(ferr_a),
        .valid(valid_a), .ready(ready_a), .count(count_a), .overrun(ovr_a), .clr_overrun(clr_a));
    uart_rx_fifo #(.BIT_PERIOD(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .in(line_b), .out(out_b), .out_perr(perr_b), .out_ferr(ferr_b),
        .valid(valid_b), .ready(ready_b), .count(count_b), .overrun(ovr_b), .clr_overrun(clr_b));
    uart_rx_fifo #(.BIT_PERIOD(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .rst(rst), .in(line_c), .out(out_c), .out_perr(perr_c), .out_ferr(ferr_c),
        .valid(valid_c), .ready(ready_c), .count(count_c), .overrun(ovr_c), .clr_overrun(clr_c));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Lines change 1 time unit after a rising edge and hold for the given cycles.
    task automatic drive(input int idx, input logic v, input int cycles);
        case (idx)
            0:       line_a = v;
            1:       line_b = v;
            default: line_c = v;
        endcase
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [7:0] d, input int nbits,
                        input bit has_par, input logic par, input logic stop);
        drive(idx, 1'b0, 4);
        for (int i = 0; i < nbits; i++)
            drive(idx, d[i], 4);
        if (has_par)
            drive(idx, par, 4);
        drive(idx, stop, 4);
    endtask

    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            $display("pop a data=%h perr=%b ferr=%b", out_a, perr_a, ferr_a);
            if (exp_a.size() == 0) check("a_unexpected_pop", {22'd0, perr_a, ferr_a, out_a}, 32'hffff_ffff);
            else check("a_pop", {22'd0, perr_a, ferr_a, out_a}, {22'd0, exp_a.pop_front()});
        end
        if (!rst && valid_b && ready_b) begin
            $display("pop b data=%h perr=%b ferr=%b", out_b, perr_b, ferr_b);
            if (exp_b.size() == 0) check("b_unexpected_pop", {22'd0, perr_b, ferr_b, out_b}, 32'hffff_ffff);
            else check("b_pop", {22'd0, perr_b, ferr_b, out_b}, {22'd0, exp_b.pop_front()});
        end
        if (!rst && valid_c && ready_c) begin
            $display("pop c data=%h perr=%b ferr=%b", out_c, perr_c, ferr_c);
            if (exp_c.size() == 0) check("c_unexpected_pop", {22'd0, perr_c, ferr_c, out_c}, 32'hffff_ffff);
            else check("c_pop", {22'd0, perr_c, ferr_c, out_c}, {22'd0, exp_c.pop_front()});
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {24'd0, out_a}, 32'd0);
        check("reset_valid", {29'd0, valid_a, valid_b, valid_c}, 32'd0);
        check("reset_count", {24'd0, count_a, count_c}, 32'd0);
        check("reset_overrun", {29'd0, ovr_a, ovr_b, ovr_c}, 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // back-to-back 8N1 frames
        exp_a.push_back(10'h055);
        exp_a.push_back(10'h0A3);
        send(0, 8'h55, 8, 1'b0, 1'b0, 1'b1);
        send(0, 8'hA3, 8, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 20);
        check("t1_overrun", {31'd0, ovr_a}, 32'd0);
        check("t1_count", {27'd0, count_a}, 32'd0);

        // short low glitch must be rejected
        drive(0, 1'b0, 2);
        drive(0, 1'b1, 20);
        check("t2_count", {27'd0, count_a}, 32'd0);
        check("t2_valid", {31'd0, valid_a}, 32'd0);

        // 7 data bits, odd parity: 0x41 has two ones, so the correct parity bit is 1
        exp_b.push_back(10'h241);
        send(1, 8'h41, 7, 1'b1, 1'b0, 1'b1);
        exp_b.push_back(10'h041);
        send(1, 8'h41, 7, 1'b1, 1'b1, 1'b1);
        drive(1, 1'b1, 20);

        // framing error followed by a held-low break, then a clean frame
        exp_a.push_back(10'h17E);
        send(0, 8'h7E, 8, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 12);
        exp_a.push_back(10'h012);
        send(0, 8'h12, 8, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b1, 20);
        check("t4_count", {27'd0, count_a}, 32'd0);

        // depth-4 FIFO overflow with consumer stalled
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_c.push_back(10'(i));
            send(2, 8'(i), 8, 1'b0, 1'b0, 1'b1);
        end
        drive(2, 1'b1, 12);
        check("t5_count_full", {29'd0, count_c}, 32'd4);
        check("t5_overrun_set", {31'd0, ovr_c}, 32'd1);
        ready_c = 1'b1;
        drive(2, 1'b1, 12);
        check("t5_count_drained", {29'd0, count_c}, 32'd0);
        check("t5_overrun_sticky", {31'd0, ovr_c}, 32'd1);
        clr_c = 1'b1;
        @(posedge clk);
        #1;
        clr_c = 1'b0;
        check("t5_overrun_clr", {31'd0, ovr_c}, 32'd0);

        // reset in the middle of the data bits of 0xFF
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 10);
        rst = 1'b1;
        drive(0, 1'b1, 2);
        rst = 1'b0;
        check("t6_valid", {31'd0, valid_a}, 32'd0);
        check("t6_count", {27'd0, count_a}, 32'd0);
        drive(0, 1'b1, 8);
        exp_a.push_back(10'h03C);
        send(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 200 && (exp_a.size() + exp_b.size() + exp_c.size()) != 0; n++)
            @(posedge clk);
        #1;
        check("end_queue_a", exp_a.size(), 32'd0);
        check("end_queue_b", exp_b.size(), 32'd0);
        check("end_queue_c", exp_c.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
